// File: rtl/seq_pkg.sv
// Shared types and constants for the serial sequence transmitter and detectors.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    FIN   = 2'd3
  } seq_tx_state_t;

  localparam int SEQ_PAT_W = 4;
  localparam int SEQ_CNT_W = 8;
  localparam int SEQ_GAP_W = 4;

  // The detector side matches against the same constant.
  localparam logic [SEQ_PAT_W-1:0] SEQ_PAT_1010 = 4'b1010;

endpackage

// File: rtl/seq_shift_reg.sv
// Parallel-load, MSB-first shift register; last flags that the MSB holds the pattern LSB.
module seq_shift_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] load_data,
  output logic         next_bit,
  output logic         last
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  logic [W-1:0]  data_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg <= '0;
      cnt_reg  <= '0;
    end else if (load) begin
      data_reg <= load_data;
      cnt_reg  <= CW'(W - 1);
    end else if (shift) begin
      data_reg <= {data_reg[W-2:0], 1'b0};
      cnt_reg  <= cnt_reg - CW'(1);
    end
  end

  // Bit that reaches the MSB after the next shift.
  assign next_bit = data_reg[W-2];
  assign last     = (cnt_reg == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: repeats PATTERN MSB first with optional idle gaps.
// Define SEQ_TX_PARITY_EN to append an even-parity bit to every repetition.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int                PAT_W   = SEQ_PAT_W,
  parameter logic [PAT_W-1:0]  PATTERN = SEQ_PAT_1010,
  parameter int                CNT_W   = SEQ_CNT_W,
  parameter int                GAP_W   = SEQ_GAP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_count
);

  seq_tx_state_t    state_reg, state_next;
  logic [CNT_W-1:0] rep_lat_reg, rep_lat_next;
  logic [GAP_W-1:0] gap_lat_reg, gap_lat_next;
  logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic [CNT_W-1:0] sent_count_reg, sent_count_next;
  logic             out_reg, out_valid_reg, busy_reg, done_reg;
  logic             out_next;
  logic             sr_load, sr_shift, sr_next_bit, sr_last;
  logic             rep_end;

`ifdef SEQ_TX_PARITY_EN
  localparam logic PARITY = ^PATTERN;
  logic par_reg, par_next;
`endif

  seq_shift_reg #(.W(PAT_W)) u_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (sr_load),
    .shift     (sr_shift),
    .load_data (PATTERN),
    .next_bit  (sr_next_bit),
    .last      (sr_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      rep_lat_reg    <= '0;
      gap_lat_reg    <= '0;
      gap_cnt_reg    <= '0;
      sent_count_reg <= '0;
      out_reg        <= 1'b0;
      out_valid_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
      par_reg        <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      rep_lat_reg    <= rep_lat_next;
      gap_lat_reg    <= gap_lat_next;
      gap_cnt_reg    <= gap_cnt_next;
      sent_count_reg <= sent_count_next;
      out_reg        <= out_next;
      out_valid_reg  <= (state_next == SHIFT);
      busy_reg       <= (state_next == SHIFT) || (state_next == GAP);
      done_reg       <= (state_next == FIN);
`ifdef SEQ_TX_PARITY_EN
      par_reg        <= par_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    rep_lat_next    = rep_lat_reg;
    gap_lat_next    = gap_lat_reg;
    gap_cnt_next    = gap_cnt_reg;
    sent_count_next = sent_count_reg;
    sr_load         = 1'b0;
    sr_shift        = 1'b0;
    out_next        = 1'b0;
    rep_end         = sr_last;
`ifdef SEQ_TX_PARITY_EN
    par_next        = par_reg;
    rep_end         = par_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          sent_count_next = '0;
          if (repeat_cnt != '0) begin
            state_next   = SHIFT;
            sr_load      = 1'b1;
            rep_lat_next = repeat_cnt;
            gap_lat_next = gap;
          end else begin
            state_next = FIN;
          end
        end
      end
      SHIFT: begin
`ifdef SEQ_TX_PARITY_EN
        if (par_reg)
          par_next = 1'b0;
        else if (sr_last)
          par_next = 1'b1;
`endif
        if (rep_end) begin
          sent_count_next = sent_count_reg + CNT_W'(1);
          if (sent_count_next == rep_lat_reg) begin
            state_next = FIN;
          end else if (gap_lat_reg == '0) begin
            sr_load = 1'b1;
          end else begin
            state_next   = GAP;
            gap_cnt_next = gap_lat_reg;
          end
        end else begin
          sr_shift = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_reg <= GAP_W'(1)) begin
          state_next = SHIFT;
          sr_load    = 1'b1;
        end else begin
          gap_cnt_next = gap_cnt_reg - GAP_W'(1);
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Abort leaves sent_count as it stands and suppresses the done pulse.
    if (abort && (state_reg != IDLE)) begin
      state_next      = IDLE;
      sr_load         = 1'b0;
      sr_shift        = 1'b0;
      sent_count_next = sent_count_reg;
`ifdef SEQ_TX_PARITY_EN
      par_next        = 1'b0;
`endif
    end

    if (state_next == SHIFT) begin
      if (sr_load)
        out_next = PATTERN[PAT_W-1];
`ifdef SEQ_TX_PARITY_EN
      else if (par_next)
        out_next = PARITY;
`endif
      else
        out_next = sr_next_bit;
    end
  end

  assign out        = out_reg;
  assign out_valid  = out_valid_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign sent_count = sent_count_reg;

endmodule
